// File: rtl/nway_pipe_mux_if.sv
// Bundle for the N-way pipelined channel multiplexer.
// The producer side (data/valid per channel plus the mode/select controls and
// the consumer's ready) and the consumer side (registered beat plus the
// per-channel accepts) travel together so a single port carries the whole bus.
interface nway_pipe_mux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    // Environment view: drives producers, controls and the consumer accept.
    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Multiplexer view.
    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/nway_pipe_mux.sv
// Registered N-way, W-bit channel multiplexer with valid/ready handshaking.
// One output beat register with backpressure; the channel is chosen either
// directly by sel (mode=0) or by a round-robin scan starting at a pointer
// that advances past each channel it serves (mode=1).
// SEL_W is expected to equal clog2(CHANNELS), with CHANNELS in 2..64.
module nway_pipe_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    nway_pipe_mux_if.slave   bus
);

    logic                 loadEn;
    logic                 directValid;
    logic                 scanValid;
    logic [SEL_W-1:0]     scanIdx;
    logic                 lowValid;
    logic [SEL_W-1:0]     lowIdx;
    logic                 highValid;
    logic [SEL_W-1:0]     highIdx;
    logic                 grantValid;
    logic [SEL_W-1:0]     grantIdx;
    logic [WIDTH-1:0]     grantData;
    logic [CHANNELS-1:0]  readyVec;

    logic [WIDTH-1:0]     outData_q,  outData_d;
    logic [SEL_W-1:0]     outCh_q,    outCh_d;
    logic                 outValid_q, outValid_d;
    logic [SEL_W-1:0]     ptr_q,      ptr_d;

    // The output register can take a new beat when it is empty or being drained.
    assign loadEn = !outValid_q || bus.out_ready;

    // Direct mode grants only when sel names an existing channel that is valid;
    // an out-of-range sel simply matches no channel.
    always_comb begin
        directValid = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.sel == SEL_W'(c) && bus.in_valid[c]) begin
                directValid = 1'b1;
            end
        end
    end

    // Scan mode: lowest valid channel at or above the pointer wins, otherwise
    // wrap around to the lowest valid channel overall.
    always_comb begin
        lowValid  = 1'b0;
        lowIdx    = '0;
        highValid = 1'b0;
        highIdx   = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (bus.in_valid[c]) begin
                lowValid = 1'b1;
                lowIdx   = SEL_W'(c);
                if (SEL_W'(c) >= ptr_q) begin
                    highValid = 1'b1;
                    highIdx   = SEL_W'(c);
                end
            end
        end
        scanValid = lowValid;
        scanIdx   = highValid ? highIdx : lowIdx;
    end

    // Mode picks which selector drives the grant; both react in the same cycle.
    always_comb begin
        grantValid = bus.mode ? scanValid : directValid;
        grantIdx   = bus.mode ? scanIdx   : bus.sel;
    end

    // Route the granted channel's data toward the output register.
    always_comb begin
        grantData = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grantIdx == SEL_W'(c)) begin
                grantData = bus.in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Accept is one-hot on the granted channel and forced low while in reset.
    always_comb begin
        readyVec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            readyVec[c] = rst_n && loadEn && grantValid && (grantIdx == SEL_W'(c));
        end
    end

    assign bus.in_ready = readyVec;

    // Next output beat and scan pointer; everything holds unless a load happens.
    always_comb begin
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        if (loadEn) begin
            if (grantValid) begin
                outData_d  = grantData;
                outCh_d    = grantIdx;
                outValid_d = 1'b1;
                if (bus.mode) begin
                    ptr_d = (grantIdx == SEL_W'(CHANNELS - 1)) ? '0 : grantIdx + 1'b1;
                end
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    // Output beat and scan pointer registers; reset drops any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.out_data  = outData_q;
    assign bus.out_ch    = outCh_q;
    assign bus.out_valid = outValid_q;

endmodule
